// File: rtl/axis_labcontrol_transmitter_pkg.sv
// ---------------------------------------------------------------------------
// axis_labcontrol_pkg
//
// Shared constants for the LabControl transmit path:
//   - bit positions inside the DIOD control byte
//   - LabControl field widths
//   - transmitter FSM state encoding
//   - a small elaboration-time helper used to size the timing counter
// ---------------------------------------------------------------------------
package axis_labcontrol_pkg;

  // DIOD layout: {reserved[2:0], subbus[2:0], direction, strobe}
  localparam int STROBE_BIT = 0;
  localparam int DIR_BIT    = 1;
  localparam int SUBBUS_LSB = 2;
  localparam int RESV_LSB   = 5;

  // LabControl field widths
  localparam int LC_DATA_W   = 16;
  localparam int LC_ADDR_W   = 8;
  localparam int LC_SUBBUS_W = 3;
  localparam int LC_RESV_W   = 3;

  // Transmitter write-cycle phases
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } lc_state_t;

  // Largest of three cycle counts; the timing counter must hold any of them
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/axis_labcontrol_transmitter_if.sv
// ---------------------------------------------------------------------------
// axis_labcontrol_transmitter_if
//
// AXI4-Stream handshake bundle feeding the LabControl transmitter.
//   tdata  : sample (DATA_WIDTH bits)
//   tvalid : sample valid, driven by the source
//   tready : sink ready, driven by the transmitter
// Modports:
//   master : the stream source (DSP side / testbench)
//   slave  : the transmitter
// ---------------------------------------------------------------------------
interface axis_labcontrol_transmitter_if #(
  parameter int DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_labcontrol_transmitter_conv.sv
// ---------------------------------------------------------------------------
// axis_labcontrol_transmitter_conv
//
// Purely combinational width / sign / saturation converter from an AXIS
// sample to the LabControl data field.
//   din  : AXIS sample, AXIS_DATA_WIDTH bits
//   dout : LabControl data word, LC_DATA_WIDTH bits
// Behaviour by width relation:
//   equal   : pass through
//   narrower: sign-extend (TWOS_COMPL=1) or zero-extend (TWOS_COMPL=0)
//   wider   : SATURATE=0 keeps the LSBs; SATURATE=1 clamps to the LC range
//             (signed range for TWOS_COMPL=1, all-ones ceiling otherwise)
// ---------------------------------------------------------------------------
module axis_labcontrol_transmitter_conv #(
  parameter int AXIS_DATA_WIDTH = 16,
  parameter int LC_DATA_WIDTH   = 16,
  parameter bit TWOS_COMPL      = 1'b1,
  parameter bit SATURATE        = 1'b1
) (
  input  logic [AXIS_DATA_WIDTH-1:0] din,
  output logic [LC_DATA_WIDTH-1:0]   dout
);

  localparam int AW = AXIS_DATA_WIDTH;
  localparam int LW = LC_DATA_WIDTH;

  generate
    if (AW == LW) begin : g_pass
      assign dout = din;

    end else if (AW < LW) begin : g_extend
      logic ext_bit;
      assign ext_bit = TWOS_COMPL ? din[AW-1] : 1'b0;
      assign dout    = {{(LW-AW){ext_bit}}, din};

    end else if (!SATURATE) begin : g_truncate
      assign dout = din[LW-1:0];

    end else if (TWOS_COMPL) begin : g_clamp_signed
      // The value fits the LC range exactly when every bit from the LC sign
      // bit upward is a copy of the AXIS sign bit.
      logic [AW-LW:0] upper;
      logic           in_range;
      assign upper    = din[AW-1:LW-1];
      assign in_range = (&upper) | ~(|upper);

      always_comb begin
        dout = din[LW-1:0];
        if (!in_range) begin
          if (din[AW-1]) dout = {1'b1, {(LW-1){1'b0}}};
          else           dout = {1'b0, {(LW-1){1'b1}}};
        end
      end

    end else begin : g_clamp_unsigned
      logic [AW-LW-1:0] upper;
      assign upper = din[AW-1:LW];
      assign dout  = (|upper) ? {LW{1'b1}} : din[LW-1:0];
    end
  endgenerate

endmodule

// File: rtl/axis_labcontrol_transmitter.sv
// ---------------------------------------------------------------------------
// axis_labcontrol_transmitter
//
// AXI4-Stream slave that writes every accepted sample onto the LabControl
// parallel bus as bus master. Each word produces one write cycle made of a
// setup phase, a strobe pulse and a hold phase, with programmable lengths.
//
// Ports:
//   s_axis_aclk   : system clock
//   s_axis_areset : synchronous reset, active-high
//   s_axis        : AXIS slave (tdata / tvalid / tready)
//   DIOA          : LC data[15:8]
//   DIOB          : LC data[7:0]
//   DIOC          : LC address
//   DIOD          : {reserved[2:0]=0, subbus[2:0], direction, strobe}
//   dio_oe        : pad output enable
//   busy          : write cycle in progress
//
// All DIO outputs, dio_oe and busy come straight from flops. tready is a
// decode of the state register (gated low while reset is asserted), so there
// is no combinational path from tvalid to tready.
// ---------------------------------------------------------------------------
module axis_labcontrol_transmitter
  import axis_labcontrol_pkg::*;
#(
  parameter int         AXIS_DATA_WIDTH = 16,
  parameter int         LC_DATA_WIDTH   = 16,
  parameter logic [7:0] LC_ADDRESS      = 8'hFF,
  parameter logic [2:0] LC_SUBBUS       = 3'd0,
  parameter logic       LC_DIRECTION    = 1'b1,
  parameter bit         TWOS_COMPL      = 1'b1,
  parameter bit         SATURATE        = 1'b1,
  parameter int         SETUP_CYCLES    = 2,
  parameter int         STROBE_CYCLES   = 4,
  parameter int         HOLD_CYCLES     = 2
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_areset,
  axis_labcontrol_transmitter_if.slave  s_axis,
  output logic [7:0]                    DIOA,
  output logic [7:0]                    DIOB,
  output logic [7:0]                    DIOC,
  output logic [7:0]                    DIOD,
  output logic                          dio_oe,
  output logic                          busy
);

  // One extra bit over the largest phase length keeps the reload values
  // clear of the counter's top bit.
  localparam int CNT_MAX = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

  lc_state_t state, state_next;

  logic [CNT_W-1:0]         count, count_next;
  logic [LC_DATA_W-1:0]     data_q, data_next;
  logic [LC_ADDR_W-1:0]     addr_q, addr_next;
  logic [7:0]               diod_q, diod_next;
  logic                     oe_q, oe_next;
  logic                     busy_q, busy_next;
  logic [7:0]               diod_write;
  logic [LC_DATA_WIDTH-1:0] conv_data;
  logic                     tready;

  axis_labcontrol_transmitter_conv #(
    .AXIS_DATA_WIDTH (AXIS_DATA_WIDTH),
    .LC_DATA_WIDTH   (LC_DATA_WIDTH),
    .TWOS_COMPL      (TWOS_COMPL),
    .SATURATE        (SATURATE)
  ) u_conv (
    .din  (s_axis.tdata),
    .dout (conv_data)
  );

  // Ready only while idle; held low during reset so no word is taken while
  // the bus is being cleared.
  assign tready        = (state == ST_IDLE) && !s_axis_areset;
  assign s_axis.tready = tready;

  // Control byte driven for every write, strobe bit low; reserved bits stay 0.
  always_comb begin
    diod_write                                = '0;
    diod_write[SUBBUS_LSB +: LC_SUBBUS_W]     = LC_SUBBUS;
    diod_write[DIR_BIT]                       = LC_DIRECTION;
  end

  // Next-state and next-register logic. Bus registers default to holding
  // their value, so the pins keep the last word after the cycle completes
  // and only change on the update that follows an accept.
  always_comb begin
    state_next = state;
    count_next = count;
    data_next  = data_q;
    addr_next  = addr_q;
    diod_next  = diod_q;
    oe_next    = oe_q;

    unique case (state)
      ST_IDLE: begin
        if (s_axis.tvalid && tready) begin
          data_next  = conv_data;
          addr_next  = LC_ADDRESS;
          diod_next  = diod_write;
          oe_next    = 1'b1;
          count_next = SETUP_LOAD;
          state_next = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (count == '0) begin
          diod_next[STROBE_BIT] = 1'b1;
          count_next            = STROBE_LOAD;
          state_next            = ST_STROBE;
        end else begin
          count_next = count - 1'b1;
        end
      end

      ST_STROBE: begin
        if (count == '0) begin
          diod_next[STROBE_BIT] = 1'b0;
          count_next            = HOLD_LOAD;
          state_next            = ST_HOLD;
        end else begin
          count_next = count - 1'b1;
        end
      end

      ST_HOLD: begin
        if (count == '0) begin
          state_next = ST_IDLE;
        end else begin
          count_next = count - 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  // State and output registers. Reset drops the in-flight word entirely:
  // strobe, bus and output enable all return to zero on the next edge.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state  <= ST_IDLE;
      count  <= '0;
      data_q <= '0;
      addr_q <= '0;
      diod_q <= '0;
      oe_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      data_q <= data_next;
      addr_q <= addr_next;
      diod_q <= diod_next;
      oe_q   <= oe_next;
      busy_q <= busy_next;
    end
  end

  assign DIOA   = data_q[15:8];
  assign DIOB   = data_q[7:0];
  assign DIOC   = addr_q;
  assign DIOD   = diod_q;
  assign dio_oe = oe_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_axis_labcontrol_transmitter.sv
// ---------------------------------------------------------------------------
// tb_axis_labcontrol_transmitter
//
// Bench for the LabControl transmitter. A timeline model predicts every
// output from "cycles since the last accepted word"; a small LabControl
// receiver model captures words on strobe rising edges for loopback checks.
// Standalone converter instances cover the non-default width settings.
// ---------------------------------------------------------------------------
module tb_axis_labcontrol_transmitter;

  localparam int         T_SETUP  = 2;
  localparam int         T_STROBE = 4;
  localparam int         T_HOLD   = 2;
  localparam int         T_PERIOD = 1 + T_SETUP + T_STROBE + T_HOLD;
  localparam logic [7:0] ADDR     = 8'hFF;
  localparam logic [2:0] SUBBUS   = 3'd0;
  localparam logic       DIR      = 1'b1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] DIOA, DIOB, DIOC, DIOD;
  logic       dio_oe, busy;

  always #5 clk = ~clk;

  axis_labcontrol_transmitter_if #(.DATA_WIDTH(16)) s_axis ();

  axis_labcontrol_transmitter #(
    .AXIS_DATA_WIDTH (16),
    .LC_DATA_WIDTH   (16),
    .LC_ADDRESS      (ADDR),
    .LC_SUBBUS       (SUBBUS),
    .LC_DIRECTION    (DIR),
    .TWOS_COMPL      (1'b1),
    .SATURATE        (1'b1),
    .SETUP_CYCLES    (T_SETUP),
    .STROBE_CYCLES   (T_STROBE),
    .HOLD_CYCLES     (T_HOLD)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis        (s_axis),
    .DIOA          (DIOA),
    .DIOB          (DIOB),
    .DIOC          (DIOC),
    .DIOD          (DIOD),
    .dio_oe        (dio_oe),
    .busy          (busy)
  );

  // Standalone converters for the other width configurations
  logic [23:0] c24_in;
  logic [11:0] c12_in;
  logic [15:0] c24_sat_s, c24_wrap_s, c24_sat_u, c12_s, c12_u;

  axis_labcontrol_transmitter_conv #(.AXIS_DATA_WIDTH(24), .LC_DATA_WIDTH(16), .TWOS_COMPL(1'b1), .SATURATE(1'b1))
    u_c24_sat_s (.din(c24_in), .dout(c24_sat_s));
  axis_labcontrol_transmitter_conv #(.AXIS_DATA_WIDTH(24), .LC_DATA_WIDTH(16), .TWOS_COMPL(1'b1), .SATURATE(1'b0))
    u_c24_wrap_s (.din(c24_in), .dout(c24_wrap_s));
  axis_labcontrol_transmitter_conv #(.AXIS_DATA_WIDTH(24), .LC_DATA_WIDTH(16), .TWOS_COMPL(1'b0), .SATURATE(1'b1))
    u_c24_sat_u (.din(c24_in), .dout(c24_sat_u));
  axis_labcontrol_transmitter_conv #(.AXIS_DATA_WIDTH(12), .LC_DATA_WIDTH(16), .TWOS_COMPL(1'b1), .SATURATE(1'b1))
    u_c12_s (.din(c12_in), .dout(c12_s));
  axis_labcontrol_transmitter_conv #(.AXIS_DATA_WIDTH(12), .LC_DATA_WIDTH(16), .TWOS_COMPL(1'b0), .SATURATE(1'b1))
    u_c12_u (.din(c12_in), .dout(c12_u));

  int vectors     = 0;
  int miscompares = 0;

  // Model state: cycles since the last accepted word (-1 = none since reset)
  int          since = -1;
  logic [15:0] m_data = '0;
  logic        m_oe = 1'b0;
  logic [15:0] sent_q[$];
  logic [15:0] rx_q[$];

  // Receiver model: latch data on a strobe rising edge addressed to rx_addr
  logic [7:0] rx_addr = 8'hFF;
  logic       strobe_prev = 1'b0;

  always @(negedge clk) begin
    if (DIOD[0] && !strobe_prev && DIOC == rx_addr && DIOD[1])
      rx_q.push_back({DIOA, DIOB});
    strobe_prev = DIOD[0];
  end

  // Numeric reference for the converter: interpret, clamp or wrap, truncate
  function automatic logic [15:0] ref_conv(input longint raw, input int aw, input bit twos, input bit sat);
    longint v;
    v = raw & ((longint'(1) << aw) - 1);
    if (twos && v >= (longint'(1) << (aw - 1))) v = v - (longint'(1) << aw);
    if (sat && aw > 16) begin
      if (twos) begin
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
      end else if (v > 65535) begin
        v = 65535;
      end
    end
    return 16'(v);
  endfunction

  function automatic logic [34:0] model_outputs();
    logic act, strobe, rdy;
    logic [7:0] c, d;
    act    = (since >= 0) && (since < T_PERIOD - 1);
    strobe = (since >= T_SETUP) && (since < T_SETUP + T_STROBE);
    rdy    = !rst && !act;
    c      = m_oe ? ADDR : 8'h00;
    d      = m_oe ? {3'b000, SUBBUS, DIR, strobe} : 8'h00;
    return {rdy, act, m_oe, m_data, c, d};
  endfunction

  function automatic logic [34:0] dut_outputs();
    return {s_axis.tready, busy, dio_oe, DIOA, DIOB, DIOC, DIOD};
  endfunction

  // Advance one clock: update the model from the inputs we drove, then
  // return at the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      since  = -1;
      m_data = '0;
      m_oe   = 1'b0;
    end else if (s_axis.tvalid && (since < 0 || since >= T_PERIOD - 1)) begin
      since  = 0;
      m_data = ref_conv(longint'(s_axis.tdata), 16, 1'b1, 1'b1);
      m_oe   = 1'b1;
      sent_q.push_back(s_axis.tdata);
    end else if (since >= 0 && since < 1000) begin
      since++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (dut_outputs() !== model_outputs()) begin
        miscompares++;
        $display("[TB] FAIL reset cycle %0d: got %h expected %h", i, dut_outputs(), model_outputs());
      end
    end
    rst           = 1'b0;
    s_axis.tvalid = 1'b0;
    #1;
    vectors++;
    if (s_axis.tready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_reset: got %b expected 1", s_axis.tready);
    end
    tick();
  endtask

  task automatic test_single_word();
    s_axis.tdata  = 16'hBEEF;
    s_axis.tvalid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      s_axis.tvalid = 1'b0;
      vectors++;
      if (dut_outputs() !== model_outputs()) begin
        miscompares++;
        $display("[TB] FAIL single_word cycle %0d: got %h expected %h", i, dut_outputs(), model_outputs());
      end
      if (i == 0) begin
        vectors++;
        if ({DIOA, DIOB, DIOC, DIOD} !== 32'hBEEF_FF02) begin
          miscompares++;
          $display("[TB] FAIL beef_bus: got %h expected beefff02", {DIOA, DIOB, DIOC, DIOD});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words[3];
    int          accept_cycle[$];
    int          idx;
    words = '{16'h0001, 16'h0002, 16'h0003};
    sent_q.delete();
    rx_q.delete();
    idx           = 0;
    s_axis.tdata  = words[0];
    s_axis.tvalid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      vectors++;
      if (dut_outputs() !== model_outputs()) begin
        miscompares++;
        $display("[TB] FAIL back_to_back cycle %0d: got %h expected %h", cyc, dut_outputs(), model_outputs());
      end
      if (since == 0) begin
        accept_cycle.push_back(cyc);
        idx++;
        if (idx < 3) s_axis.tdata = words[idx];
        else         s_axis.tvalid = 1'b0;
      end
    end
    vectors++;
    if (accept_cycle.size() != 3) begin
      miscompares++;
      $display("[TB] FAIL b2b_accepts: got %0d expected 3", accept_cycle.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (accept_cycle[i] - accept_cycle[i-1] != T_PERIOD) begin
          miscompares++;
          $display("[TB] FAIL b2b_period %0d: got %0d expected %0d", i, accept_cycle[i] - accept_cycle[i-1], T_PERIOD);
        end
      end
    end
    vectors++;
    if (rx_q.size() != 3 || rx_q[0] !== 16'h0001 || rx_q[1] !== 16'h0002 || rx_q[2] !== 16'h0003) begin
      miscompares++;
      $display("[TB] FAIL b2b_pulses: got %0d words expected 1,2,3", rx_q.size());
    end
  endtask

  task automatic test_random_loopback();
    int cycles;
    cycles = 0;
    sent_q.delete();
    rx_q.delete();
    rx_addr       = ADDR;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = 16'($urandom);
    while (sent_q.size() < 100 && cycles < 3000) begin
      tick();
      cycles++;
      vectors++;
      if (dut_outputs() !== model_outputs()) begin
        miscompares++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", cycles, dut_outputs(), model_outputs());
      end
      if (since == 0 || !s_axis.tvalid) begin
        s_axis.tvalid = ($urandom_range(0, 3) != 0);
        s_axis.tdata  = 16'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        s_axis.tvalid = 1'b0;
      end
    end
    s_axis.tvalid = 1'b0;
    if (sent_q.size() < 100) begin
      miscompares++;
      $display("[TB] FAIL random_budget: got %0d words expected 100", sent_q.size());
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (dut_outputs() !== model_outputs()) begin
        miscompares++;
        $display("[TB] FAIL random_flush cycle %0d: got %h expected %h", i, dut_outputs(), model_outputs());
      end
    end
    vectors++;
    if (rx_q.size() != sent_q.size()) begin
      miscompares++;
      $display("[TB] FAIL loopback_count: got %0d expected %0d", rx_q.size(), sent_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++) begin
      vectors++;
      if (rx_q[i] !== sent_q[i]) begin
        miscompares++;
        $display("[TB] FAIL loopback_word %0d: got %h expected %h", i, rx_q[i], sent_q[i]);
      end
    end
  endtask

  task automatic test_address_mismatch();
    sent_q.delete();
    rx_q.delete();
    rx_addr       = 8'h5A;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = 16'($urandom);
    for (int cyc = 0; cyc < 10 * T_PERIOD + 12; cyc++) begin
      tick();
      vectors++;
      if (dut_outputs() !== model_outputs()) begin
        miscompares++;
        $display("[TB] FAIL mismatch cycle %0d: got %h expected %h", cyc, dut_outputs(), model_outputs());
      end
      if (since == 0) begin
        if (sent_q.size() < 10) s_axis.tdata  = 16'($urandom);
        if (sent_q.size() >= 10) s_axis.tvalid = 1'b0;
      end
    end
    vectors++;
    if (sent_q.size() != 10 || rx_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL mismatch_rx: got sent %0d rx %0d expected sent 10 rx 0", sent_q.size(), rx_q.size());
    end
    rx_addr = ADDR;
  endtask

  task automatic test_reset_mid();
    sent_q.delete();
    rx_q.delete();
    s_axis.tdata  = 16'($urandom);
    s_axis.tvalid = 1'b1;
    tick();
    s_axis.tvalid = 1'b0;
    for (int i = 0; i < 10 && since != T_SETUP + 1; i++) tick();
    vectors++;
    if (DIOD[0] !== 1'b1 || since != T_SETUP + 1) begin
      miscompares++;
      $display("[TB] FAIL mid_strobe_high: got strobe %b expected 1", DIOD[0]);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({dio_oe, busy, DIOA, DIOB, DIOC, DIOD} !== 34'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_clear: got %h expected 0", {dio_oe, busy, DIOA, DIOB, DIOC, DIOD});
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (dut_outputs() !== model_outputs()) begin
        miscompares++;
        $display("[TB] FAIL mid_reset_after cycle %0d: got %h expected %h", i, dut_outputs(), model_outputs());
      end
    end
    vectors++;
    if (sent_q.size() != 1 || rx_q.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_replay: got sent %0d rx %0d expected 1 1", sent_q.size(), rx_q.size());
    end
  endtask

  task automatic test_conv();
    logic [23:0] v24[4];
    logic [15:0] e24[4];
    v24 = '{24'h7FFFFF, 24'h800000, 24'hFFFF80, 24'h001234};
    e24 = '{16'h7FFF, 16'h8000, 16'hFF80, 16'h1234};
    for (int i = 0; i < 4; i++) begin
      c24_in = v24[i];
      #1;
      vectors++;
      if (c24_sat_s !== e24[i]) begin
        miscompares++;
        $display("[TB] FAIL conv24_sat %h: got %h expected %h", v24[i], c24_sat_s, e24[i]);
      end
    end
    c24_in = 24'h7FFFFF;
    c12_in = 12'h800;
    #1;
    vectors++;
    if (c24_wrap_s !== 16'hFFFF || c12_s !== 16'hF800 || c12_u !== 16'h0800) begin
      miscompares++;
      $display("[TB] FAIL conv_table: got %h %h %h expected ffff f800 0800", c24_wrap_s, c12_s, c12_u);
    end
    c12_in = 12'h7FF;
    #1;
    vectors++;
    if (c12_s !== 16'h07FF) begin
      miscompares++;
      $display("[TB] FAIL conv12_pos: got %h expected 07ff", c12_s);
    end
    for (int i = 0; i < 40; i++) begin
      c24_in = (i % 4 == 0) ? {8'h00, 16'($urandom)} : 24'($urandom);
      c12_in = 12'($urandom);
      #1;
      vectors++;
      if ({c24_sat_s, c24_wrap_s, c24_sat_u, c12_s, c12_u} !==
          {ref_conv(longint'(c24_in), 24, 1'b1, 1'b1), ref_conv(longint'(c24_in), 24, 1'b1, 1'b0),
           ref_conv(longint'(c24_in), 24, 1'b0, 1'b1), ref_conv(longint'(c12_in), 12, 1'b1, 1'b1),
           ref_conv(longint'(c12_in), 12, 1'b0, 1'b1)}) begin
        miscompares++;
        $display("[TB] FAIL conv_random %h/%h: got %h %h %h %h %h", c24_in, c12_in,
                 c24_sat_s, c24_wrap_s, c24_sat_u, c12_s, c12_u);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    c24_in        = '0;
    c12_in        = '0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_random_loopback();
    test_address_mismatch();
    test_reset_mid();
    test_conv();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_labcontrol_transmitter.md
Name: axis_labcontrol_transmitter

Overview:
AXI4-Stream slave that writes each accepted sample onto the LabControl parallel bus as a bus master.
- It is the transmit-side counterpart of the LabControl receiver interface.
- Each word is converted to LC_DATA_WIDTH and driven on DIOA/DIOB, with the target address on DIOC and control on DIOD.
- Each word produces one strobe cycle with programmable setup, pulse-width and hold timing.
- It sits between a DSP/AXIS source and the external DIO pins (tristate control via dio_oe).

Parameters:
AXIS_DATA_WIDTH, 16, width of s_axis_tdata (8..32)
LC_DATA_WIDTH, 16, LabControl data field width (fixed {DIOA,DIOB})
LC_ADDRESS, 'hFF, value driven on DIOC for every write
LC_SUBBUS, 0, 3-bit value driven on DIOD[4:2]
LC_DIRECTION, 1, value driven on DIOD[1] during writes
TWOS_COMPL, 1, 1 = signed conversion; 0 = unsigned
SATURATE, 1, when AXIS_DATA_WIDTH > LC_DATA_WIDTH: 1 = clamp to the LC range, 0 = take LSBs
SETUP_CYCLES, 2, cycles data/address are stable before strobe rises (>=1)
STROBE_CYCLES, 4, strobe high time in cycles (>=3, so a 2-flop synchronized receiver on a similar clock detects it)
HOLD_CYCLES, 2, cycles data/address are stable after strobe falls (>=1)

Ports:
s_axis_aclk  in  1  system clock
s_axis_areset  in  1  synchronous reset, active-high
s_axis_tdata  in  AXIS_DATA_WIDTH  sample to transmit
s_axis_tvalid  in  1  sample valid
s_axis_tready  out  1  block ready to accept a sample
DIOA  out  8  LC data[15:8]
DIOB  out  8  LC data[7:0]
DIOC  out  8  LC address
DIOD  out  8  {reserved[2:0]=0, subbus[2:0], direction, strobe}
dio_oe  out  1  pad output enable
busy  out  1  transfer in progress (state != IDLE)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: s_axis_tready=0 during reset, then 1 from the first cycle after reset deasserts. DIOA..DIOD=0, dio_oe=0, busy=0, state=IDLE, counter=0.
- All DIO outputs, dio_oe and busy are registered.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - tready=1.
  - On tvalid&tready, register the converted data into {DIOA,DIOB}, LC_ADDRESS into DIOC, and {3'b0,LC_SUBBUS,LC_DIRECTION,1'b0} into DIOD.
  - Set dio_oe=1, load counter=SETUP_CYCLES-1, go to SETUP.
- SETUP:
  - tready=0, strobe=0.
  - When counter==0: set DIOD[0]=1, load counter=STROBE_CYCLES-1, go to STROBE.
  - Otherwise decrement the counter.
- STROBE:
  - tready=0, strobe=1.
  - When counter==0: set strobe=0, load counter=HOLD_CYCLES-1, go to HOLD.
- HOLD:
  - tready=0, strobe=0.
  - When counter==0: go to IDLE. DIO values and dio_oe=1 are retained (the bus keeps the last value; no glitch to 0).
- Timing:
  - Strobe rises SETUP_CYCLES cycles after the first DIO update.
  - Strobe is high exactly STROBE_CYCLES cycles.
  - Word period (handshake to next possible handshake) = 1+SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES (defaults: 9).
- Data and address never change while busy=1; they change only on the register update following an accept.
- tready depends only on state (no combinational path from tvalid).
- tvalid dropping without a handshake has no effect. Back-to-back valid is accepted at one word per period.
- Width conversion, combinational on tdata, registered at accept:
  - Equal widths: pass through.
  - AXIS narrower: sign-extend if TWOS_COMPL, else zero-extend.
  - AXIS wider, SATURATE=0: take the LSBs.
  - AXIS wider, SATURATE=1, TWOS_COMPL=1: clamp to [0x8000, 0x7FFF] for LC_DATA_WIDTH=16.
  - AXIS wider, SATURATE=1, TWOS_COMPL=0: clamp to 0xFFFF.
- Reset mid-transfer: the next edge forces strobe=0, all DIO=0, dio_oe=0, IDLE. The in-flight word is discarded, not replayed.
- The counter is sized by $clog2 of the largest cycle parameter, +1 bit.

Decomposition:
- Package axis_labcontrol_pkg holds the shared constants:
  - DIOD bit positions (STROBE_BIT=0, DIR_BIT=1, SUBBUS_LSB=2, RESV_LSB=5).
  - LC field widths (data 16, addr 8, subbus 3, resv 3).
  - FSM state encoding.
- Sub-module axis_labcontrol_transmitter_conv: purely combinational width/sign/saturation converter, parameterised by AXIS_DATA_WIDTH, LC_DATA_WIDTH, TWOS_COMPL and SATURATE. It can be unit-tested standalone.

Test Plan:
1. Defaults, single word 0xBEEF -> DIOA=0xBE, DIOB=0xEF, DIOC=0xFF, DIOD=0x02 after accept. DIOD[0] rises 2 cycles later, stays high 4 cycles, then 2 hold cycles. tready returns high 9 cycles after the handshake.
2. Continuous tvalid with 0x0001, 0x0002, 0x0003 -> exactly one accept per 9 cycles, three strobe pulses. DIO data constant within each pulse window; strobe never high while data changes.
3. AXIS_DATA_WIDTH=24, TWOS_COMPL=1, SATURATE=1 -> 0x7FFFFF→0x7FFF, 0x800000→0x8000, 0xFFFF80→0xFF80, 0x001234→0x1234. With SATURATE=0, 0x7FFFFF→0xFFFF.
4. AXIS_DATA_WIDTH=12, TWOS_COMPL=1 -> 0x800→0xF800, 0x7FF→0x07FF. With TWOS_COMPL=0, 0x800→0x0800.
5. Reset asserted in the 2nd STROBE cycle -> next edge: strobe=0, DIO=0, dio_oe=0, busy=0. After release, tready=1 and the word is not retransmitted.
6. Loopback: connect DIOA..D to the LabControl receiver interface (same clock, LC_ADDRESS match) and send 100 random words -> the receiver emits an identical sequence on its AXIS output. Repeat with LC_ADDRESS mismatched -> zero words received.
